// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer: FSM states,
// exception cause codes, default vectors and the sequential PC increment.
package pc_sequencer_pkg;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_ISSUE = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_EXT      = 2'd1,
    CAUSE_MISALIGN = 2'd2
  } cause_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_0180;
  localparam logic [31:0] PC_INC       = 32'd4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_sequencer_npc_sel.sv
// Next-PC priority mux: exc > eret > jmp > branch > pc+4; a misaligned jump or
// branch target becomes an exception to EXC_VEC. Purely combinational.
module pc_sequencer_npc_sel
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
  input  logic [31:0] i_pc,
  input  logic [31:0] i_epc,
  input  logic        i_exc,
  input  logic        i_eret,
  input  logic        i_jmp,
  input  logic [31:0] i_jmp_target,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  output logic [31:0] o_npc,
  output logic        o_misalign,
  output logic        o_eret_sel,
  output cause_e      o_cause
);

  always_comb begin
    o_npc      = i_pc + PC_INC;
    o_misalign = 1'b0;
    o_eret_sel = 1'b0;
    o_cause    = CAUSE_NONE;
    if (i_exc) begin
      o_npc   = EXC_VEC;
      o_cause = CAUSE_EXT;
    end else if (i_eret) begin
      o_npc      = i_epc;
      o_eret_sel = 1'b1;
    end else if (i_jmp) begin
      if (is_misaligned(i_jmp_target)) begin
        o_npc      = EXC_VEC;
        o_misalign = 1'b1;
        o_cause    = CAUSE_MISALIGN;
      end else begin
        o_npc = i_jmp_target;
      end
    end else if (i_br_taken) begin
      if (is_misaligned(i_br_target)) begin
        o_npc      = EXC_VEC;
        o_misalign = 1'b1;
        o_cause    = CAUSE_MISALIGN;
      end else begin
        o_npc = i_br_target;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/retire sequencer: one imem req/ack per instruction, IR held while stalled.
// Minimum 2 cycles per instruction; each ack wait or stall cycle adds one.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        exc,
  input  logic        eret,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic        exl,
  output logic [1:0]  exc_cause
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic        r_exl;
  cause_e      r_cause;
  logic [31:0] r_ir;

  logic        w_fetch_done;
  logic        w_retire;
  logic [31:0] w_npc;
  logic        w_misalign;
  logic        w_eret_sel;
  cause_e      w_cause;
  logic        w_enter_exc;

  pc_sequencer_npc_sel #(
    .EXC_VEC (EXC_VEC)
  ) u_npc_sel (
    .i_pc         (r_pc),
    .i_epc        (r_epc),
    .i_exc        (exc),
    .i_eret       (eret),
    .i_jmp        (jmp),
    .i_jmp_target (jmp_target),
    .i_br_taken   (br_taken),
    .i_br_target  (br_target),
    .o_npc        (w_npc),
    .o_misalign   (w_misalign),
    .o_eret_sel   (w_eret_sel),
    .o_cause      (w_cause)
  );

  assign w_enter_exc = exc | w_misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_fetch_done = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (imem_ack) begin
          w_fetch_done = 1'b1;
          w_state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir <= '0;
    end else if (w_fetch_done) begin
      r_ir <= imem_rdata;
    end
  end

  // EPC captures only the first exception; nested ones keep the original return point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_epc   <= '0;
      r_exl   <= 1'b0;
      r_cause <= CAUSE_NONE;
    end else if (w_retire) begin
      r_pc <= w_npc;
      if (w_enter_exc) begin
        r_cause <= w_cause;
        if (!r_exl) begin
          r_epc <= r_pc;
          r_exl <= 1'b1;
        end
      end else if (w_eret_sel) begin
        r_exl   <= 1'b0;
        r_cause <= CAUSE_NONE;
      end
    end
  end

  // Gated by rst so the request drops the instant reset asserts.
  assign imem_req  = (r_state == S_FETCH) && rst;
  assign imem_addr = r_pc;
  assign ir        = r_ir;
  assign ir_valid  = (r_state == S_ISSUE);
  assign pc        = r_pc;
  assign epc       = r_epc;
  assign exl       = r_exl;
  assign exc_cause = r_cause;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the MIPS core.
- Issues one instruction-memory request per instruction with a req/ack handshake, latches the returned word into the instruction register, and holds it while the datapath stalls.
- At retirement, selects the next PC from sequential, branch, jump, exception vector or exception return, and keeps EPC/EXL state.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VEC, 32'h0000_0180, PC loaded on any exception.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state immediately.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  32  fetch address; equals pc while imem_req is high.
- imem_ack  in  1  memory accepted the request and imem_rdata is valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- ir  out  32  current instruction register.
- ir_valid  out  1  ir holds an instruction awaiting retirement.
- stall  in  1  datapath not ready; current instruction must not retire.
- br_taken  in  1  conditional branch taken for the current instruction.
- br_target  in  32  branch target.
- jmp  in  1  jump for the current instruction.
- jmp_target  in  32  jump target.
- exc  in  1  current instruction raised an exception.
- eret  in  1  current instruction is ERET.
- pc  out  32  current program counter.
- epc  out  32  exception return address.
- exl  out  1  exception level flag.
- exc_cause  out  2  last exception cause: 0 none, 1 external exc, 2 misaligned target.

Behaviour:
- Reset (rst low, asynchronous):
  - pc=RESET_PC, epc=0, exl=0, exc_cause=0, ir=0, ir_valid=0, imem_req=0.
  - FSM goes to S_FETCH immediately.
  - Any outstanding request is abandoned; an ack arriving during reset is ignored.
- FSM states:
  - S_FETCH: imem_req=1, imem_addr=pc. On imem_ack, ir<=imem_rdata, go to S_ISSUE. Without ack, stay.
  - S_ISSUE: ir_valid=1. If stall=1, hold everything; redirect inputs are ignored. If stall=0, the instruction retires this cycle: load the next PC, ir_valid deasserts next cycle, go to S_FETCH.
- Next-PC priority at retirement, highest first:
  - exc: pc<=EXC_VEC, exc_cause<=1. If exl=0, then epc<=pc and exl<=1. If exl=1, epc is unchanged.
  - eret: pc<=epc, exl<=0, exc_cause<=0.
  - jmp: pc<=jmp_target.
  - br_taken: pc<=br_target.
  - otherwise: pc<=pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- Misaligned target: a selected jmp/br target with bits[1:0]!=0 is treated as an exception. pc<=EXC_VEC, exc_cause<=2, and epc/exl are updated as for exc.
- Simultaneous inputs: the highest-priority input wins and lower ones are ignored. exc together with eret behaves as exc.
- Latency: minimum 2 cycles per instruction (ack in the first S_FETCH cycle, then retire in S_ISSUE). Each wait cycle or stalled cycle adds 1.
- imem_addr is always word-aligned, because pc only ever takes aligned values.

Decomposition:
- Shared package holds:
  - FSM state encoding (S_FETCH, S_ISSUE).
  - exc_cause codes.
  - RESET_PC/EXC_VEC defaults.
  - Constant 32'd4.
- One natural sub-module: npc_sel, a combinational priority mux. It produces next pc, the misalign flag and the cause from pc, epc and the redirect inputs.
- FSM and registers stay in pc_sequencer.

Test Plan:
- Reset then ack every cycle, imem_rdata=0x1234_0000+n, stall=0, no redirects.
  -> imem_addr sequence 0,4,8,C; ir_valid every other cycle; ir matches rdata.
- imem_ack delayed 3 cycles, then stall=1 for 2 cycles in S_ISSUE.
  -> imem_req/imem_addr stable for 4 cycles; ir and pc held during stall; retire happens on the first stall=0 cycle.
- At pc=0x10, br_taken=1 with br_target=0x40 and jmp=1 with jmp_target=0x80.
  -> next imem_addr=0x80. Then with br_taken only, target 0x42 -> pc=0x180, exc_cause=2, epc=0x80 (the pc of the retiring jump-target instruction), exl=1.
- exc at pc=0x20 -> pc=0x180, epc=0x20, exl=1.
  - A second exc at 0x184 -> epc stays 0x20.
  - eret -> pc=0x20, exl=0.
- pc=0xFFFF_FFFC retiring sequentially -> next imem_addr=0x0000_0000.
- rst low mid-S_FETCH with imem_req=1 -> imem_req=0 and pc=0 in the same cycle, without waiting for a clock edge. After release, the fetch restarts at 0.
